// File: rtl/rr_arb_pkg.sv
// Shared types and widths for the 4-requester round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_e;

    localparam int RR_N     = 4;
    localparam int RR_PTR_W = 2;
    localparam int RR_CNT_W = 8;

    // Index of the set bit in a one-hot (or zero) vector.
    function automatic logic [RR_PTR_W-1:0] oh2idx(input logic [RR_N-1:0] oh);
        logic [RR_PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RR_N; i++) begin
            if (oh[i]) idx = idx | RR_PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin pick: first set req bit at ptr, ptr+1, ... (mod 4).
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [RR_N-1:0]     req,
    input  logic [RR_PTR_W-1:0] ptr,
    output logic [RR_N-1:0]     sel,
    output logic                any
);

    logic [2*RR_N-1:0] dbl_req;
    logic [2*RR_N-1:0] dbl_pri;
    logic [RR_N-1:0]   rot;
    logic [RR_N-1:0]   pri;

    always_comb begin
        // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
        dbl_req = {req, req} >> ptr;
        rot     = dbl_req[RR_N-1:0];
        pri     = rot & (~rot + RR_N'(1));
        dbl_pri = {pri, pri} << ptr;
        sel     = dbl_pri[2*RR_N-1:RR_N];
        any     = |req;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter with registered one-hot grant, held until release.
// Optional RR_ARB_REQ_DROP_RELEASE_EN: owner dropping its req releases like done.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         timeout
);

    if (N != RR_N) begin : g_bad_n
        $error("rr_arbiter_4: N must be 4");
    end
    if (TIMEOUT < 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_arbiter_4: TIMEOUT must be 0..255");
    end

    localparam logic [RR_CNT_W-1:0] CNT_LAST = RR_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    rr_state_e             state_q, state_d;
    logic [RR_N-1:0]       gnt_q, gnt_d;
    logic [RR_PTR_W-1:0]   ptr_q, ptr_d;
    logic [RR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  to_q, to_d;
    logic [RR_N-1:0]       pick_sel;
    logic                  pick_any;
    logic                  wd_exp;
    logic                  drop_rel;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        wd_exp   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        drop_rel = 1'b0;
`ifdef RR_ARB_REQ_DROP_RELEASE_EN
        drop_rel = ~|(req & gnt_q);
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_sel;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done || wd_exp || drop_rel) begin
                    gnt_d   = '0;
                    ptr_d   = oh2idx(gnt_q) + RR_PTR_W'(1);
                    state_d = IDLE;
                    // done outranks the watchdog, so no pulse when both coincide
                    to_d    = !done && wd_exp;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + RR_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == GRANT);
    assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed literal cases plus randomized
// traffic compared every cycle against a behavioural owner/pointer model.
module tb_rr_arbiter_4;

    localparam int TO = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arbiter_4 #(.N(4), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: who owns the bus, how long it has held it, next priority.
    int   m_owner;   // -1 when nobody owns
    int   m_ptr;
    int   m_held;    // cycles the current grant has been visible
    logic m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                    end
                    m_held = 1;
                end
            end else begin
                bit expire;
                bit drop;
                expire = (TO != 0) && (m_held == TO);
                drop   = 1'b0;
`ifdef RR_ARB_REQ_DROP_RELEASE_EN
                drop   = !req[m_owner];
`endif
                if (done || expire || drop) begin
                    m_to    = !done && expire;
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_held = m_held + 1;
                end
            end
        end
    end

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        total++;
        if (gnt !== model_gnt() || busy !== (m_owner >= 0) || timeout !== m_to) begin
            bad++;
            $display("FAIL model t=%0t gnt=%b busy=%b timeout=%b want gnt=%b busy=%b timeout=%b",
                     $time, gnt, busy, timeout, model_gnt(), (m_owner >= 0), m_to);
        end
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL time_limit t=%0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", {3'b0, busy}, 4'b0000);
        chk("rst_timeout", {3'b0, timeout}, 4'b0000);
        rst_n = 1'b1;
        req   = 4'b0000;

        // 0101 from ptr 0, release, re-grant two edges later to bit 2
        @(negedge clk); req = 4'b0101;
        @(negedge clk); chk("t2_first", gnt, 4'b0001); done = 1'b1;
        @(negedge clk); chk("t2_release", gnt, 4'b0000); done = 1'b0;
        @(negedge clk); chk("t2_regrant", gnt, 4'b0100); done = 1'b1; req = 4'b0000;
        @(negedge clk); done = 1'b0;

        // rotation with all requesting
        reset_dut();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk($sformatf("t3_gnt%0d", i), gnt, 4'b0001 << (i % 4)); done = 1'b1;
            @(negedge clk); chk($sformatf("t3_gap%0d", i), gnt, 4'b0000); done = 1'b0;
        end

        // watchdog: exactly TO cycles of grant, then a one-cycle pulse
        reset_dut();
        req = 4'b0010;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold%0d", i), gnt, 4'b0010);
            chk($sformatf("t4_noto%0d", i), {3'b0, timeout}, 4'b0000);
        end
        @(negedge clk);
        chk("t4_expired", gnt, 4'b0000);
        chk("t4_pulse", {3'b0, timeout}, 4'b0001);
        req = 4'b0011;
        @(negedge clk);
        chk("t4_wrap", gnt, 4'b0001);
        chk("t4_pulse_end", {3'b0, timeout}, 4'b0000);
        done = 1'b1; req = 4'b0000;
        @(negedge clk); done = 1'b0;

        // asynchronous reset mid-grant
        reset_dut();
        req = 4'b1000;
        @(negedge clk); chk("t5_gnt", gnt, 4'b1000);
        #2 rst_n = 1'b0;
        #1 chk("t5_async", gnt, 4'b0000);
        chk("t5_async_busy", {3'b0, busy}, 4'b0000);
        @(negedge clk); rst_n = 1'b1; req = 4'b1001;
        @(negedge clk); chk("t5_after", gnt, 4'b0001);
        done = 1'b1; req = 4'b0000;
        @(negedge clk); done = 1'b0;

        // owner drops its request
        reset_dut();
        req = 4'b0100;
        @(negedge clk); chk("t6_gnt", gnt, 4'b0100); req = 4'b0000;
        @(negedge clk);
`ifdef RR_ARB_REQ_DROP_RELEASE_EN
        chk("t6_drop", gnt, 4'b0000);
`else
        chk("t6_hold", gnt, 4'b0100);
`endif
        chk("t6_noto", {3'b0, timeout}, 4'b0000);
        done = 1'b1;
        @(negedge clk); done = 1'b0;

        // randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) r = 4'b0000;
            req   = r;
            done  = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
